// File: rtl/led8_pkg.sv
// Shared types and constants for the eight-LED pattern sequencer.
`timescale 1ns/1ps
package led8_pkg;

  localparam int LED_W = 8;

  localparam logic [1:0] MODE_L2R   = 2'd0;
  localparam logic [1:0] MODE_R2L   = 2'd1;
  localparam logic [1:0] MODE_FILL  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/led8_prescaler.sv
// Step prescaler: one tick every DIV enabled cycles.
`timescale 1ns/1ps
module led8_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

  // a clear in the same cycle swallows the tick
  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/led8_pattern_seq.sv
// Eight-LED pattern sequencer: L2R, R2L, FILL and BLINK passes.
`timescale 1ns/1ps
module led8_pattern_seq
  import led8_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             hold,
  input  logic             mode_req,
  input  logic [1:0]       mode_sel,
  output logic [LED_W-1:0] LED8,
  output logic [1:0]       mode,
  output logic             step,
  output logic             wrap
);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [2:0]       idx_q, idx_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [LED_W-1:0] pat;
  logic             tick;
  logic             psc_en;
  logic             psc_clr;

  assign psc_en  = en && (state_q == RUN);
  assign psc_clr = (state_q == IDLE) || mode_req;

  led8_prescaler #(
    .DIV (DIV)
  ) u_psc (
    .clk   (clk),
    .reset (reset),
    .en    (psc_en),
    .clr   (psc_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_L2R;
      idx_q   <= 3'd0;
      led_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          mode_d  = MODE_L2R;
          idx_d   = 3'd0;
          step_d  = 1'b1;
        end
      end
      RUN: begin
        if (mode_req) begin
          mode_d = mode_sel;
          idx_d  = 3'd0;
          step_d = 1'b1;
          wrap_d = 1'b1;
        end else if (tick) begin
          idx_d  = idx_q + 3'd1;
          step_d = 1'b1;
          if (idx_q == 3'd7) begin
            wrap_d = 1'b1;
            if (!hold) mode_d = mode_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // decode from the next mode/idx so LED8 lands with the new step
  always_comb begin
    pat = '0;
    unique case (mode_d)
      MODE_L2R:   pat = 8'h80 >> idx_d;
      MODE_R2L:   pat = 8'h01 << idx_d;
      MODE_FILL:  pat = 8'hFF << (3'd7 - idx_d);
      MODE_BLINK: pat = idx_d[0] ? 8'h00 : 8'hFF;
      default:    pat = '0;
    endcase
    led_d = (state_d == RUN) ? pat : '0;
  end

  always_comb begin
    LED8 = led_q;
    mode = mode_q;
    step = step_q;
    wrap = wrap_q;
  end

endmodule

// File: tb/tb_led8_pattern_seq.sv
// Randomised and directed bench for led8_pattern_seq against a step model.
`timescale 1ns/1ps
module tb_led8_pattern_seq;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       hold = 1'b0;
  logic       mode_req = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic [7:0] LED8;
  logic [1:0] mode;
  logic       step;
  logic       wrap;

  int n_cmp = 0;
  int n_bad = 0;

  int m_run, m_mode, m_idx, m_cyc, m_led, m_step, m_wrap;

  always #10 clk = ~clk;

  led8_pattern_seq #(
    .DIV (DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .hold     (hold),
    .mode_req (mode_req),
    .mode_sel (mode_sel),
    .LED8     (LED8),
    .mode     (mode),
    .step     (step),
    .wrap     (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pattern(input int m, input int i);
    case (m)
      0:       return 128 >> i;
      1:       return 1 << i;
      2:       return 256 - (1 << (7 - i));
      default: return (i % 2 == 0) ? 255 : 0;
    endcase
  endfunction

  task automatic model_step();
    m_step = 0;
    m_wrap = 0;
    if (reset) begin
      m_run = 0; m_mode = 0; m_idx = 0; m_cyc = 0; m_led = 0;
    end else if (m_run == 0) begin
      if (en) begin
        m_run = 1; m_mode = 0; m_idx = 0; m_cyc = 0;
        m_step = 1;
        m_led = pattern(0, 0);
      end
    end else if (mode_req) begin
      m_mode = int'(mode_sel); m_idx = 0; m_cyc = 0;
      m_step = 1; m_wrap = 1;
      m_led = pattern(m_mode, 0);
    end else if (en) begin
      m_cyc++;
      if (m_cyc == DIV) begin
        m_cyc = 0;
        m_step = 1;
        m_idx = (m_idx + 1) % 8;
        if (m_idx == 0) begin
          m_wrap = 1;
          if (!hold) m_mode = (m_mode + 1) % 4;
        end
        m_led = pattern(m_mode, m_idx);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("led", 32'(LED8), 32'(m_led));
    chk("mode", 32'(mode), 32'(m_mode));
    chk("step", 32'(step), 32'(m_step));
    chk("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    m_run = 0; m_mode = 0; m_idx = 0; m_cyc = 0;
    m_led = 0; m_step = 0; m_wrap = 0;

    reset = 1'b1;
    cycn(2);
    chk("rst_led", 32'(LED8), 32'h0);
    reset = 1'b0;

    // idle ignores a mode request
    mode_req = 1'b1; mode_sel = 2'd3;
    cyc();
    mode_req = 1'b0;
    chk("idle_mode", 32'(mode), 32'd0);
    chk("idle_led", 32'(LED8), 32'h0);

    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < DIV; j++) begin
        cyc();
        chk("l2r_seq", 32'(LED8), 32'(8'h80 >> k));
      end
    end
    cyc();
    chk("r2l_led", 32'(LED8), 32'h01);
    chk("r2l_mode", 32'(mode), 32'd1);
    chk("r2l_wrap", 32'(wrap), 32'd1);

    cycn(31); cyc();
    chk("fill_mode", 32'(mode), 32'd2);
    chk("fill_led0", 32'(LED8), 32'h80);
    cycn(27); cyc();
    chk("fill_led7", 32'(LED8), 32'hFF);
    cycn(3); cyc();
    chk("blink_mode", 32'(mode), 32'd3);
    chk("blink_on", 32'(LED8), 32'hFF);
    cycn(3); cyc();
    chk("blink_off", 32'(LED8), 32'h00);
    cycn(27); cyc();
    chk("loop_mode", 32'(mode), 32'd0);
    chk("loop_led", 32'(LED8), 32'h80);
    chk("loop_wrap", 32'(wrap), 32'd1);

    hold = 1'b1;
    cycn(27); cyc();
    chk("hold_last", 32'(LED8), 32'h01);
    cycn(3); cyc();
    chk("hold_led", 32'(LED8), 32'h80);
    chk("hold_mode", 32'(mode), 32'd0);
    chk("hold_wrap", 32'(wrap), 32'd1);
    hold = 1'b0;

    cycn(7); cyc();
    chk("pause_at", 32'(LED8), 32'h20);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("pause_led", 32'(LED8), 32'h20);
      chk("pause_step", 32'(step), 32'd0);
    end
    en = 1'b1;
    cycn(3); cyc();
    chk("resume_led", 32'(LED8), 32'h10);

    cycn(3);
    mode_req = 1'b1; mode_sel = 2'd2;
    cyc();
    mode_req = 1'b0;
    chk("req_led", 32'(LED8), 32'h80);
    chk("req_mode", 32'(mode), 32'd2);
    chk("req_step", 32'(step), 32'd1);
    chk("req_wrap", 32'(wrap), 32'd1);
    cycn(3); cyc();
    chk("req_next", 32'(LED8), 32'hC0);

    mode_req = 1'b1; mode_sel = 2'd1;
    cyc();
    mode_req = 1'b0;
    cycn(7); cyc();
    chk("mid_led", 32'(LED8), 32'h04);
    cycn(1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    en = 1'b0;
    chk("rst_mid_led", 32'(LED8), 32'h00);
    chk("rst_mid_mode", 32'(mode), 32'd0);
    chk("rst_mid_step", 32'(step), 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rst_nostep", 32'(step), 32'd0);
    end
    en = 1'b1;
    cyc();
    chk("rerun_led", 32'(LED8), 32'h80);
    chk("rerun_step", 32'(step), 32'd1);

    for (int k = 0; k < 3000; k++) begin
      reset    = ($urandom_range(0, 299) == 0);
      en       = ($urandom_range(0, 99) < 85);
      hold     = ($urandom_range(0, 99) < 30);
      mode_req = ($urandom_range(0, 99) < 4);
      mode_sel = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led8_pattern_seq.md
LED8_PATTERN_SEQ -- requirements
Module: led8_pattern_seq

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clock cycles per pattern step (legal range 2..2^16).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  run enable; 0 pauses the block.
REQ-005 SHALL have port hold  input  1  1 repeats current mode instead of advancing.
REQ-006 SHALL have port mode_req  input  1  single-cycle manual mode-change strobe.
REQ-007 SHALL have port mode_sel  input  2  requested mode, sampled when mode_req=1.
REQ-008 SHALL have port LED8  output  8  LED drive, bit 7 leftmost.
REQ-009 SHALL have port mode  output  2  current mode: 0 L2R, 1 R2L, 2 FILL, 3 BLINK.
REQ-010 SHALL have port step  output  1  one-cycle pulse in the first cycle LED8 shows a new step value.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse in the first cycle of a new mode pass.

Function
REQ-012 SHALL implement states IDLE and RUN; the RUN state holds mode, step index idx (0..7) and prescaler cnt (0..DIV-1).
REQ-013 SHALL stay in IDLE with LED8=0 until the first cycle with en=1, then enter RUN with mode=0, idx=0, cnt=0; LED8=8'h80 from the next cycle.
REQ-014 SHALL in RUN increment cnt each cycle with en=1; the tick is cnt==DIV-1 with en=1, and cnt wraps to 0.
REQ-015 SHALL on a tick advance idx by 1; at idx=7, idx becomes 0.
REQ-016 SHALL at idx=7 with hold=0 advance mode in the order 0->1->2->3->0; with hold=1, mode is unchanged.
REQ-017 SHALL pulse wrap on every transition from idx=7 to idx=0, whether or not hold=1.
REQ-018 SHALL derive the LED8 patterns from mode and idx:
- L2R: 8'h80 >> idx.
- R2L: 8'h01 << idx.
- FILL: the top idx+1 bits are 1 (80, C0, ... FF).
- BLINK: FF for even idx, 00 for odd idx.
REQ-019 SHALL register LED8 and update it exactly one cycle after the tick or state change that selects the new value.
REQ-020 SHALL, while en=0 in RUN, freeze cnt, idx, mode and LED8, drive step=0 and wrap=0, and not return to IDLE.
REQ-021 SHALL, on mode_req=1 in RUN, set mode=mode_sel, idx=0 and cnt=0, and pulse step and wrap with the new LED8 value next cycle.
REQ-022 SHALL let mode_req take priority over a simultaneous tick (the tick is discarded).
REQ-023 SHALL accept mode_req even when en=0; the block remains paused at the new mode's idx=0 pattern.
REQ-024 SHALL ignore mode_req in IDLE.
REQ-025 SHALL accept a mode_req equal to the current mode and restart that mode at idx=0.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, set the state to IDLE and set mode=0, idx=0, cnt=0, LED8=0, step=0 and wrap=0.
REQ-027 SHALL give reset priority over en, hold and mode_req, and SHALL abort a run in progress mid-step with no residual pulse.
REQ-028 SHALL require en=1 again after reset release before RUN is re-entered.

Structure
REQ-029 SHALL place in shared package led8_pkg:
- the mode encoding constants MODE_L2R, MODE_R2L, MODE_FILL and MODE_BLINK;
- the state typedef (IDLE/RUN);
- the LED width constant 8.
REQ-030 SHALL instantiate one sub-module, led8_prescaler: parameter DIV, inputs clk, reset, en and clr, output tick.
REQ-031 SHALL keep the pattern decode as combinational logic feeding the LED8 register inside led8_pattern_seq.

Verification
REQ-032 SHALL verify basic run: DIV=4, 20 ns clock, reset for 2 cycles, then en=1, hold=0 -> LED8 sequence 80,40,20,10,08,04,02,01, each value held 4 cycles, then 01,02,... with wrap=1 and mode=1.
REQ-033 SHALL verify full cycle: run 32 steps -> modes 0,1,2,3 in order; FILL step 7 = FF; BLINK = FF,00 alternating; mode returns to 0 with LED8=80.
REQ-034 SHALL verify hold: hold=1 during L2R -> after 01, LED8=80 again, mode stays 0 and wrap pulses.
REQ-035 SHALL verify pause: en=0 for 10 cycles at LED8=20 -> LED8 stays 20 and step=0; after en=1 it resumes, reaching 10 after 4 cycles.
REQ-036 SHALL verify manual request: mode_req=1, mode_sel=2 in the same cycle as a tick -> next cycle LED8=80, mode=2, step=1, wrap=1; the following step is C0.
REQ-037 SHALL verify reset mid-operation: reset=1 while LED8=04 in R2L -> next cycle LED8=00, mode=0, IDLE; no step until en is reasserted.
